// File: rtl/pwr_seq_ctrl.sv
// Supervised rail sequencer: staged VCORE->P1V8->P3V3->P1V1 bring-up, PG timeout/loss
// fault latching and reverse-order power-down, all outputs registered.
module pwr_seq_ctrl #(
  parameter int DLY_VCORE_MS  = 6,
  parameter int DLY_P1V8_MS   = 6,
  parameter int DLY_P3V3_MS   = 6,
  parameter int DLY_RST_MS    = 10,
  parameter int PG_TIMEOUT_MS = 50,
  parameter int OFF_DLY_MS    = 2,
  parameter int CW            = 11
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       ms_tick,
  input  logic       pwr_req,
  input  logic       vcore_pwrgd,
  input  logic       p1v8_pwrgd,
  input  logic       p3v3_pwrgd,
  input  logic       p1v1_pwrgd,
  output logic       p1v8_en,
  output logic       p3v3_en,
  output logic       p1v1_en,
  output logic       rst_out_n,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_W_VCORE = 3'd1,
    S_W_P1V8  = 3'd2,
    S_W_P3V3  = 3'd3,
    S_W_P1V1  = 3'd4,
    S_ON      = 3'd5,
    S_PWRDN   = 3'd6,
    S_FAULT   = 3'd7
  } state_e;

  localparam logic [CW-1:0] DLY_VCORE = CW'(DLY_VCORE_MS);
  localparam logic [CW-1:0] DLY_P1V8  = CW'(DLY_P1V8_MS);
  localparam logic [CW-1:0] DLY_P3V3  = CW'(DLY_P3V3_MS);
  localparam logic [CW-1:0] DLY_RST   = CW'(DLY_RST_MS);
  localparam logic [CW-1:0] PG_TO     = CW'(PG_TIMEOUT_MS);
  localparam logic [CW-1:0] OFF_DLY   = CW'(OFF_DLY_MS);

  state_e          state_q, state_d, rail_next;
  logic            stable_q, stable_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc, rail_dly;
  logic [1:0]      step_q, step_d, rail;
  logic [2:0]      code_q, code_d;
  logic [3:0]      outs_q, outs_d;
  logic            fault_q, fault_d;
  logic [3:0]      pg_vec, qual_mask, lost;
  logic            rail_pg;

  function automatic logic [1:0] lowest(input logic [3:0] v);
    if (v[0]) return 2'd0;
    if (v[1]) return 2'd1;
    if (v[2]) return 2'd2;
    return 2'd3;
  endfunction

  // Per-wait-state rail selection and the set of rails already qualified below it
  always_comb begin
    pg_vec    = {p1v1_pwrgd, p3v3_pwrgd, p1v8_pwrgd, vcore_pwrgd};
    cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    rail      = state_q[1:0] - 2'd1;
    rail_pg   = pg_vec[rail];
    qual_mask = (4'b0001 << rail) - 4'b0001;
    lost      = ~pg_vec & qual_mask;
    rail_dly  = DLY_VCORE;
    rail_next = S_W_P1V8;
    case (rail)
      2'd0: begin rail_dly = DLY_VCORE; rail_next = S_W_P1V8; end
      2'd1: begin rail_dly = DLY_P1V8;  rail_next = S_W_P3V3; end
      2'd2: begin rail_dly = DLY_P3V3;  rail_next = S_W_P1V1; end
      default: begin rail_dly = DLY_RST; rail_next = S_ON; end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    code_d   = code_q;
    case (state_q)
      S_OFF: begin
        if (pwr_req) begin
          state_d  = S_W_VCORE;
          stable_d = 1'b0;
          cnt_d    = '0;
          code_d   = 3'd0;
        end
      end
      S_W_VCORE, S_W_P1V8, S_W_P3V3, S_W_P1V1: begin
        if (|lost) begin
          state_d = S_FAULT;
          code_d  = {1'b1, lowest(lost)};
        end else if (!pwr_req) begin
          // Enter power-down at the step that drops the highest enable still set
          stable_d = 1'b0;
          cnt_d    = '0;
          case (state_q)
            S_W_VCORE: state_d = S_OFF;
            S_W_P1V8:  begin state_d = S_PWRDN; step_d = 2'd2; end
            S_W_P3V3:  begin state_d = S_PWRDN; step_d = 2'd1; end
            default:   begin state_d = S_PWRDN; step_d = 2'd0; end
          endcase
        end else if (!stable_q) begin
          if (rail_pg) begin
            stable_d = 1'b1;
            cnt_d    = '0;
          end else if (ms_tick) begin
            if (cnt_inc == PG_TO) begin
              state_d = S_FAULT;
              code_d  = {1'b0, rail};
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end else begin
          if (!rail_pg) begin
            stable_d = 1'b0;
            cnt_d    = '0;
          end else if (ms_tick) begin
            if (cnt_inc == rail_dly) begin
              state_d  = rail_next;
              stable_d = 1'b0;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
      end
      S_ON: begin
        if (|(~pg_vec)) begin
          state_d = S_FAULT;
          code_d  = {1'b1, lowest(~pg_vec)};
        end else if (!pwr_req) begin
          state_d = S_PWRDN;
          step_d  = 2'd0;
          cnt_d   = '0;
        end
      end
      S_PWRDN: begin
        if (ms_tick) begin
          if (cnt_inc == OFF_DLY) begin
            cnt_d = '0;
            if (step_q == 2'd2) state_d = S_OFF;
            else                step_d  = step_q + 2'd1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        if (!pwr_req) state_d = S_OFF;
      end
    endcase
  end

  // Output decode of the next state so outputs change on the same edge as the state
  always_comb begin
    outs_d  = 4'b0000;
    fault_d = (state_d == S_FAULT);
    case (state_d)
      S_W_P1V8: outs_d = 4'b1000;
      S_W_P3V3: outs_d = 4'b1100;
      S_W_P1V1: outs_d = 4'b1110;
      S_ON:     outs_d = 4'b1111;
      S_PWRDN: begin
        case (step_d)
          2'd0:    outs_d = 4'b1100;
          2'd1:    outs_d = 4'b1000;
          default: outs_d = 4'b0000;
        endcase
      end
      default:  outs_d = 4'b0000;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= S_OFF;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      step_q   <= 2'd0;
      code_q   <= 3'd0;
      outs_q   <= 4'b0000;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      code_q   <= code_d;
      outs_q   <= outs_d;
      fault_q  <= fault_d;
    end
  end

  assign {p1v8_en, p3v3_en, p1v1_en, rst_out_n} = outs_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign seq_state  = state_q;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Directed bench for pwr_seq_ctrl: 1 ms tick every 100 clocks, PGs raised on tick cycles
// so enable latencies are exact clock counts.
module tb_pwr_seq_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       ms_tick;
  logic       pwr_req;
  logic       vcore_pwrgd, p1v8_pwrgd, p3v3_pwrgd, p1v1_pwrgd;
  logic       p1v8_en, p3v3_en, p1v1_en, rst_out_n, fault;
  logic [2:0] fault_code, seq_state;

  int errors = 0;
  int checks = 0;
  int cycleCnt = 0;

  pwr_seq_ctrl dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .ms_tick     (ms_tick),
    .pwr_req     (pwr_req),
    .vcore_pwrgd (vcore_pwrgd),
    .p1v8_pwrgd  (p1v8_pwrgd),
    .p3v3_pwrgd  (p3v3_pwrgd),
    .p1v1_pwrgd  (p1v1_pwrgd),
    .p1v8_en     (p1v8_en),
    .p3v3_en     (p3v3_en),
    .p1v1_en     (p1v1_en),
    .rst_out_n   (rst_out_n),
    .fault       (fault),
    .fault_code  (fault_code),
    .seq_state   (seq_state)
  );

  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cycleCnt <= cycleCnt + 1;

  // Free-running 1 ms tick: one cycle high out of every 100
  initial begin
    ms_tick = 1'b0;
    forever begin
      repeat (99) @(negedge sys_clk);
      ms_tick = 1'b1;
      @(negedge sys_clk);
      ms_tick = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [9:0] expv);
    logic [9:0] obs;
    obs = {p1v8_en, p3v3_en, p1v1_en, rst_out_n, fault, fault_code, seq_state};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b (en3,rst,fault,code,state)", tag, obs, expv);
    end
  endtask

  task automatic checkVal(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic selOut(input int which);
    case (which)
      0:       return p1v8_en;
      1:       return p3v3_en;
      2:       return p1v1_en;
      default: return rst_out_n;
    endcase
  endfunction

  // Polls an output at negedges; delay is -1 if it never rises within the budget
  task automatic waitOut(input int which, input int start, output int delay);
    delay = -1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge sys_clk);
      if (selOut(which)) begin
        delay = cycleCnt - start;
        break;
      end
    end
  endtask

  task automatic tickThenSample();
    @(posedge ms_tick);
    @(negedge sys_clk);
  endtask

  task automatic allPgLow();
    vcore_pwrgd = 1'b0;
    p1v8_pwrgd  = 1'b0;
    p3v3_pwrgd  = 1'b0;
    p1v1_pwrgd  = 1'b0;
  endtask

  // Full power-up; each PG rises on a tick cycle 3 ms after its enable
  task automatic applyStimulus(input string tag);
    int start, d;
    pwr_req = 1'b1;
    repeat (3) @(posedge ms_tick);
    vcore_pwrgd = 1'b1; start = cycleCnt;
    waitOut(0, start, d);
    checkVal({tag, "/vcoreToP1v8En"}, d, 601);
    repeat (3) @(posedge ms_tick);
    p1v8_pwrgd = 1'b1; start = cycleCnt;
    waitOut(1, start, d);
    checkVal({tag, "/p1v8ToP3v3En"}, d, 601);
    repeat (3) @(posedge ms_tick);
    p3v3_pwrgd = 1'b1; start = cycleCnt;
    waitOut(2, start, d);
    checkVal({tag, "/p3v3ToP1v1En"}, d, 601);
    repeat (3) @(posedge ms_tick);
    p1v1_pwrgd = 1'b1; start = cycleCnt;
    waitOut(3, start, d);
    checkVal({tag, "/p1v1ToRstRelease"}, d, 1001);
    checkOutput({tag, "/on"}, {3'b111, 1'b1, 1'b0, 3'b000, 3'd5});
  endtask

  initial begin
    int start, d;
    sys_rst_n = 1'b0;
    pwr_req   = 1'b0;
    allPgLow();
    repeat (3) @(negedge sys_clk);
    checkOutput("resetState", 10'b0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    checkOutput("idleOff", 10'b0);

    $display("[TB] nominal power-up");
    applyStimulus("nominal");

    $display("[TB] orderly power-down with mid-sequence request pulse");
    pwr_req = 1'b0;
    @(negedge sys_clk);
    checkOutput("pdn/entry", {3'b110, 1'b0, 1'b0, 3'b000, 3'd6});
    tickThenSample();
    checkOutput("pdn/tick1", {3'b110, 1'b0, 1'b0, 3'b000, 3'd6});
    pwr_req = 1'b1;
    repeat (3) @(negedge sys_clk);
    pwr_req = 1'b0;
    tickThenSample();
    checkOutput("pdn/p3v3Off", {3'b100, 1'b0, 1'b0, 3'b000, 3'd6});
    tickThenSample();
    checkOutput("pdn/tick3", {3'b100, 1'b0, 1'b0, 3'b000, 3'd6});
    tickThenSample();
    checkOutput("pdn/p1v8Off", {3'b000, 1'b0, 1'b0, 3'b000, 3'd6});
    tickThenSample();
    checkOutput("pdn/tick5", {3'b000, 1'b0, 1'b0, 3'b000, 3'd6});
    tickThenSample();
    checkOutput("pdn/off", 10'b0);
    allPgLow();

    $display("[TB] P3V3 PG timeout");
    pwr_req = 1'b1;
    repeat (3) @(posedge ms_tick);
    vcore_pwrgd = 1'b1; start = cycleCnt;
    waitOut(0, start, d);
    checkVal("timeout/p1v8En", d, 601);
    repeat (3) @(posedge ms_tick);
    p1v8_pwrgd = 1'b1; start = cycleCnt;
    waitOut(1, start, d);
    checkVal("timeout/p3v3En", d, 601);
    repeat (49) @(posedge ms_tick);
    @(negedge sys_clk);
    checkOutput("timeout/tick49", {3'b110, 1'b0, 1'b0, 3'b000, 3'd3});
    tickThenSample();
    checkOutput("timeout/fault", {3'b000, 1'b0, 1'b1, 3'b010, 3'd7});
    repeat (5) @(negedge sys_clk);
    checkOutput("timeout/holdFault", {3'b000, 1'b0, 1'b1, 3'b010, 3'd7});
    pwr_req = 1'b0;
    @(negedge sys_clk);
    checkOutput("timeout/offRetainsCode", {3'b000, 1'b0, 1'b0, 3'b010, 3'd0});
    allPgLow();
    pwr_req = 1'b1;
    @(negedge sys_clk);
    checkOutput("timeout/restartClearsCode", {3'b000, 1'b0, 1'b0, 3'b000, 3'd1});
    pwr_req = 1'b0;
    repeat (3) @(negedge sys_clk);

    $display("[TB] PG glitch in W_P1V8 then abort in W_P3V3");
    pwr_req = 1'b1;
    repeat (3) @(posedge ms_tick);
    vcore_pwrgd = 1'b1; start = cycleCnt;
    waitOut(0, start, d);
    checkVal("glitch/p1v8En", d, 601);
    @(posedge ms_tick);
    p1v8_pwrgd = 1'b1;
    repeat (3) @(posedge ms_tick);
    @(posedge ms_tick);
    p1v8_pwrgd = 1'b0;
    @(posedge ms_tick);
    p1v8_pwrgd = 1'b1; start = cycleCnt;
    waitOut(1, start, d);
    checkVal("glitch/delayRestarted", d, 601);
    checkOutput("glitch/noFault", {3'b110, 1'b0, 1'b0, 3'b000, 3'd3});
    pwr_req = 1'b0;
    @(negedge sys_clk);
    checkOutput("abort/entry", {3'b100, 1'b0, 1'b0, 3'b000, 3'd6});
    tickThenSample();
    checkOutput("abort/tick1", {3'b100, 1'b0, 1'b0, 3'b000, 3'd6});
    tickThenSample();
    checkOutput("abort/p1v8Off", {3'b000, 1'b0, 1'b0, 3'b000, 3'd6});
    tickThenSample();
    tickThenSample();
    checkOutput("abort/off", 10'b0);
    allPgLow();

    $display("[TB] simultaneous PG loss in ON");
    applyStimulus("loss");
    p1v8_pwrgd = 1'b0;
    p1v1_pwrgd = 1'b0;
    @(negedge sys_clk);
    checkOutput("loss/fault", {3'b000, 1'b0, 1'b1, 3'b101, 3'd7});
    pwr_req = 1'b0;
    @(negedge sys_clk);
    checkOutput("loss/off", {3'b000, 1'b0, 1'b0, 3'b101, 3'd0});
    allPgLow();
    repeat (2) @(negedge sys_clk);

    $display("[TB] asynchronous reset in ON");
    applyStimulus("async");
    #3 sys_rst_n = 1'b0;
    #2 checkOutput("async/immediate", 10'b0);
    repeat (2) @(negedge sys_clk);
    checkOutput("async/held", 10'b0);
    pwr_req = 1'b0;
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwr_seq_ctrl.md
# pwr_seq_ctrl

Rail power-up/power-down sequencer with power-good supervision for the BMU CPLD. Consumes the 1 ms tick from `timer_1ms` and the four rail power-good inputs. Drives the P1V8/P3V3/P1V1 enables and the combined PCIe/PHY reset release in order, with per-rail PG timeouts, loss-of-PG fault latching and reverse-order power-down. It replaces the chain of independent `timer_n_ms` instances with a single supervised state machine.

## Interface
Parameters:
- `DLY_VCORE_MS`, 6: ms of stable VCORE_PWRGD before `p1v8_en` asserts.
- `DLY_P1V8_MS`, 6: ms of stable P1V8_PWRGD before `p3v3_en` asserts.
- `DLY_P3V3_MS`, 6: ms of stable P3V3_PWRGD before `p1v1_en` asserts.
- `DLY_RST_MS`, 10: ms of stable P1V1_PWRGD before `rst_out_n` releases.
- `PG_TIMEOUT_MS`, 50: max ms for a rail's PG to rise once its wait state is entered.
- `OFF_DLY_MS`, 2: ms between successive enable drops during power-down.
- `CW`, 11: ms counter width; all delay parameters must be ≥1 and < 2^CW.

Ports:
- `sys_clk` in 1: 50 MHz system clock.
- `sys_rst_n` in 1: asynchronous active-low reset.
- `ms_tick` in 1: single-cycle 1 ms pulse from `timer_1ms`.
- `pwr_req` in 1: power request (VCORE_EN). High means sequence up, low means sequence down.
- `vcore_pwrgd`, `p1v8_pwrgd`, `p3v3_pwrgd`, `p1v1_pwrgd` in 1 each: rail PGs. Already synchronized and deglitched upstream.
- `p1v8_en`, `p3v3_en`, `p1v1_en` out 1 each: rail enables.
- `rst_out_n` out 1: PCIe/PHY reset. Low means held in reset.
- `fault` out 1: high while in FAULT.
- `fault_code` out 3: bit 2 = 1 for PG loss, 0 for PG timeout. Bits 1:0 = rail (0 VCORE, 1 P1V8, 2 P3V3, 3 P1V1).
- `seq_state` out 3: current state encoding, for debug LEDs.

## Operation
- Outputs are registered decodes of the state and sub-step. There is no combinational path from any input to any output.
- **OFF (0)**: all enables 0, `rst_out_n`=0. `pwr_req`=1 moves to W_VCORE, clears the counter, and clears `fault_code`.
- **Wait states**: W_VCORE (1), W_P1V8 (2), W_P3V3 (3), W_P1V1 (4). Each monitors one PG and has two phases. The entry phase is PEND.
  - PEND: the counter counts `ms_tick`. If the tick that brings the count to `PG_TIMEOUT_MS` arrives with PG still low, go to FAULT with code {0, rail}. PG=1 clears the counter and enters STABLE.
  - STABLE: the counter counts ticks. PG=0 returns to PEND with the counter cleared. The timeout restarts.
  - When the tick makes count = the rail's DLY, advance to the next state with the counter cleared.
- **Enables are cumulative**:
  - Entering W_P1V8 sets `p1v8_en`.
  - Entering W_P3V3 adds `p3v3_en`.
  - Entering W_P1V1 adds `p1v1_en`.
  - W_P1V1 STABLE completion enters ON.
- **ON (5)**: all enables 1 and `rst_out_n`=1.
  - Any PG=0 goes to FAULT with code {1, lowest-index failing rail}.
  - `pwr_req`=0 goes to PWRDN.
- **Already-enabled rails in wait states**: in states 2–4, a drop of an already-qualified PG goes to FAULT with a loss code.
- **PWRDN (6)**: `rst_out_n`=0 on entry. Sub-steps:
  - Step 0: drop `p1v1_en`.
  - After `OFF_DLY_MS` ticks, step 1: drop `p3v3_en`.
  - After `OFF_DLY_MS` ticks, step 2: drop `p1v8_en`.
  - After `OFF_DLY_MS` ticks, go to OFF.
  - PG inputs are ignored in PWRDN. `pwr_req`=1 during PWRDN is ignored until OFF is reached.
- **`pwr_req`=0 in states 1–4**: go to PWRDN at the sub-step that drops the highest currently-set enable. Steps whose enable is already 0 complete immediately without waiting.
- **FAULT (7)**: all enables 0 and `rst_out_n`=0 on the entry edge, with no staged shutdown. `fault`=1.
  - Exit to OFF only when `pwr_req`=0 is sampled.
  - `fault_code` persists through OFF until the next OFF→W_VCORE transition.
- **Priority when events coincide in one cycle**: FAULT condition > `pwr_req`=0 > delay completion > PG timeout.
- **Counter**: saturates at 2^CW−1 and never wraps.

## Timing
- Reset values: state OFF, counter 0, all enables 0, `rst_out_n`=0, `fault`=0, `fault_code`=0, `seq_state`=0.
- A state change and its output change occur on the same `sys_clk` edge: the edge that samples the qualifying condition.
- Delay from PG rise to the next enable is DLY to DLY+1 ms, because of tick phase. Added logic latency is exactly 1 clock.
- `pwr_req` low in ON → `rst_out_n` low on the next edge. `p1v1_en` low on that same edge.
- PG loss in ON → all outputs off on the next edge (1-cycle response).
- Asynchronous reset at any point forces the reset values immediately.

## Test plan
- Nominal power-up: bench tick every 100 clocks. Raise `pwr_req`, then each PG 3 ms after its enable. Required: `p1v8_en` asserts 6–7 ms after `vcore_pwrgd` rises. Each later enable 6–7 ms after its PG. `rst_out_n` 10–11 ms after `p1v1_pwrgd`. `seq_state`=5.
- PG timeout: hold `p3v3_pwrgd`=0 after `p3v3_en`. Required: FAULT 50 ticks after entering W_P3V3, all outputs 0 next edge, `fault_code`=3'b010. Lower `pwr_req` → OFF, code retained. Raise again → code 0.
- PG loss in ON: drop `p1v8_pwrgd` and `p1v1_pwrgd` in the same cycle. Required: next edge all enables 0, `fault`=1, `fault_code`=3'b101.
- Orderly power-down: from ON, lower `pwr_req`. Required: `rst_out_n` and `p1v1_en` low next edge. `p3v3_en` low 2 ticks later, `p1v8_en` 2 ticks after that, OFF 2 ticks after that. `pwr_req` pulsed high mid-sequence has no effect.
- Glitch and abort: PG drops for 1 ms in W_P1V8 STABLE → delay restarts and no fault. Then lower `pwr_req` in W_P3V3 → immediate `p1v1_en`-step skip, staged drop of `p3v3_en` then `p1v8_en`.
- Async reset mid-ON: assert `sys_rst_n`=0 asynchronously between clock edges. Required: all outputs at reset values before the next edge.
